program_loader: RTL
===================

# program_loader

Boot-time writer that fills the single-port instruction/data RAM from a byte stream before the processor runs. Accepts a framed stream over a valid/ready byte handshake: word count, big-endian 16-bit words, XOR checksum. Drives the RAM write side sequentially from address 0. Holds the processor in reset until the image is written and verified.

## Interface
- `WORD_WIDTH`, default 16: RAM word and instruction width; must be a multiple of 8.
- `ADDRESS_WIDTH`, default 8: RAM address width; memory depth is 2**ADDRESS_WIDTH.
- `BYTES_PER_WORD`, derived, WORD_WIDTH/8: not overridable.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-high.
- `i_clock`  in  1  single clock; all state changes on its rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_byte_valid`  in  1  source has a byte on `i_byte`.
- `i_byte`  in  8  stream byte.
- `o_byte_ready`  out  1  loader accepts `i_byte` this cycle.
- `o_ram_write_enable`  out  1  one-cycle RAM write strobe.
- `o_ram_address`  out  ADDRESS_WIDTH  RAM write address.
- `o_ram_write_data`  out  WORD_WIDTH  RAM write data.
- `o_cpu_hold`  out  1  high keeps the processor in reset.
- `o_done`  out  1  image written and checksum matched; sticky.
- `o_error`  out  1  checksum mismatch; sticky.

## Operation
- A byte transfers on a rising edge where `i_byte_valid && o_byte_ready`. `i_byte` is sampled only then.
- Frame layout:
  - Byte 0 is count N (0..255 words).
  - Then N words, most significant byte first.
  - Then one checksum byte.
- Checksum is the XOR of the count byte and every payload byte.
- States:
  - COUNT: ready=1. On accept: latch N, set checksum to the byte, set address to 0, set byte index to 0. If N==0, go to CHECK; otherwise go to DATA.
  - DATA: ready=1. On accept: shift the byte into the word register from MSB, XOR it into the checksum, increment the byte index. On the last byte of a word, go to WRITE.
  - WRITE: ready=0. `o_ram_write_enable`=1 for exactly this cycle, with `o_ram_address` = current address and `o_ram_write_data` = assembled word. Then increment the address and decrement the remaining count. If remaining becomes 0, go to CHECK; otherwise go to DATA.
  - CHECK: ready=1. On accept: if byte == checksum, go to DONE; otherwise go to ERROR.
  - DONE: ready=0, `o_done`=1, `o_cpu_hold`=0. Terminal; exits only on `i_reset`.
  - ERROR: ready=0, `o_error`=1, `o_cpu_hold`=1. Terminal; exits only on `i_reset`.
- Address wrap: at most 255 words per frame with ADDRESS_WIDTH=8, so the address never wraps inside a frame. The address counter is ADDRESS_WIDTH bits and wraps modulo depth if the parameters are widened.
- Words beyond N are never written. RAM locations at or above N keep their prior contents.
- Bytes presented while ready=0 are not consumed. The source must hold them, per the handshake.
- Reset mid-frame returns to COUNT and discards the partial word and checksum. RAM writes already issued are not undone.

## Timing
- Reset values:
  - state = COUNT
  - `o_byte_ready`=1 (combinational from state, so high during reset)
  - `o_ram_write_enable`=0
  - `o_ram_address`=0
  - `o_ram_write_data`=0
  - `o_cpu_hold`=1
  - `o_done`=0
  - `o_error`=0
- All outputs are registered or decoded from the state register; none is combinational from inputs.
- Throughput: 1 byte/cycle in DATA. Each word costs BYTES_PER_WORD accept cycles plus 1 WRITE bubble, so a 16-bit word takes 3 cycles minimum.
- The RAM write lands on the rising edge at the end of the WRITE cycle. The RAM is write-first-safe because the processor is held in reset.
- `o_cpu_hold` deasserts on the edge entering DONE, one cycle after the checksum byte is accepted. `o_done` rises on that same edge.
- `o_ram_address` and `o_ram_write_data` hold their last written values outside WRITE. `o_ram_write_enable` is the only qualifier.
- Back-pressure from the source (valid low) in any ready state stalls with no state change.

## Test plan
- Full boot: stream 0x03, 0x61,0x01, 0x60,0x00, 0x00,0x00, then checksum 0x03^0x61^0x01^0x60=0x03.
  - Expect writes mem[0]=0x6101, mem[1]=0x6000, mem[2]=0x0000.
  - Each write enable is exactly 1 cycle.
  - `o_done`=1 and `o_cpu_hold`=0 one cycle after the checksum byte.
- Bad checksum: same frame with checksum 0x04.
  - Expect the same three writes, then `o_error`=1 and `o_cpu_hold`=1.
  - `o_byte_ready`=0 forever until reset.
- Empty frame: 0x00 then 0x00.
  - Expect no write enable and `o_done`=1.
- Back-pressure: drop valid for 5 cycles between the high and low byte of word 1.
  - Expect identical RAM contents and no spurious write.
  - `o_byte_ready` is low only in WRITE cycles.
- Reset mid-frame: assert `i_reset` after the first byte of word 2, then send a fresh 1-word frame 0x01, 0xAB,0xCD, checksum 0x01^0xAB^0xCD=0x67.
  - Expect all outputs at reset values immediately (asynchronously).
  - Expect mem[0]=0xABCD and `o_done`=1.
- Max frame: N=255 with random words.
  - Expect 255 writes at addresses 0..254 in order, followed by DONE.
  - Total accept cycles = 1+510+1.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time RAM filler: parses count, big-endian words and an XOR checksum from a
// byte stream, writes the words from address 0 and holds the CPU until verified.
module program_loader #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_byte_valid,
    input  logic [7:0]               i_byte,
    output logic                     o_byte_ready,
    output logic                     o_ram_write_enable,
    output logic [ADDRESS_WIDTH-1:0] o_ram_address,
    output logic [WORD_WIDTH-1:0]    o_ram_write_data,
    output logic                     o_cpu_hold,
    output logic                     o_done,
    output logic                     o_error
);
    // WORD_WIDTH is expected to be a whole number of bytes.
    localparam int BYTES_PER_WORD = WORD_WIDTH / 8;
    localparam int INDEX_WIDTH    = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        S_COUNT,
        S_DATA,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                   state;
    logic [7:0]               remaining;
    logic [7:0]               checksum;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [INDEX_WIDTH-1:0]   byte_index;
    logic [WORD_WIDTH-1:0]    word_shift;
    logic [WORD_WIDTH-1:0]    word_next;
    logic                     byte_accept;

    assign byte_accept = i_byte_valid && o_byte_ready;
    assign word_next   = (word_shift << 8) | WORD_WIDTH'(i_byte);

    // Every status output is a pure decode of the state register.
    assign o_byte_ready       = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
    assign o_ram_write_enable = (state == S_WRITE);
    assign o_cpu_hold         = (state != S_DONE);
    assign o_done             = (state == S_DONE);
    assign o_error            = (state == S_ERROR);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state            <= S_COUNT;
            remaining        <= '0;
            checksum         <= '0;
            address          <= '0;
            byte_index       <= '0;
            o_ram_address    <= '0;
            o_ram_write_data <= '0;
        end else begin
            case (state)
                S_COUNT: begin
                    if (byte_accept) begin
                        remaining  <= i_byte;
                        checksum   <= i_byte;
                        address    <= '0;
                        byte_index <= '0;
                        state      <= (i_byte == 8'd0) ? S_CHECK : S_DATA;
                    end
                end
                S_DATA: begin
                    if (byte_accept) begin
                        checksum <= checksum ^ i_byte;
                        if (byte_index == LAST_INDEX) begin
                            // Latch address/data now so they stay put after the write.
                            byte_index       <= '0;
                            o_ram_address    <= address;
                            o_ram_write_data <= word_next;
                            state            <= S_WRITE;
                        end else begin
                            byte_index <= byte_index + INDEX_WIDTH'(1);
                        end
                    end
                end
                S_WRITE: begin
                    address   <= address + ADDRESS_WIDTH'(1);
                    remaining <= remaining - 8'd1;
                    state     <= (remaining == 8'd1) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (byte_accept) begin
                        state <= (i_byte == checksum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE:  state <= S_DONE;
                S_ERROR: state <= S_ERROR;
                // An unreachable encoding keeps the CPU held rather than releasing it.
                default: state <= S_ERROR;
            endcase
        end
    end

    // Assembly register carries only data; stale bytes are fully shifted out per word.
    always_ff @(posedge i_clock) begin
        if (state == S_DATA && byte_accept) begin
            word_shift <= word_next;
        end
    end

endmodule
